// File: rtl/serial_word_controller.sv
// Serial-to-parallel framing controller: gathers WIDTH serial bits into a word
// and holds it on a valid/ready port, with backpressure and a synchronous flush.
module serial_word_controller #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ser_in,
   input  logic             ser_valid,
   output logic             ser_ready,
   input  logic             flush,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   input  logic             word_ready,
   output logic [4:0]       bit_count
);

   typedef enum logic {COLLECT, HOLD} state_t;

   localparam logic [4:0] LAST = 5'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sr, sr_nxt;
   logic [WIDTH-1:0] word_nxt;
   logic [4:0]       cnt_nxt;
   logic             accept;

   // In HOLD a bit may only enter when the held word leaves on the same edge.
   assign ser_ready  = !flush && ((state == COLLECT) || word_ready);
   assign accept     = ser_valid && ser_ready;
   assign word_valid = (state == HOLD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= COLLECT;
         sr        <= '0;
         word_out  <= '0;
         bit_count <= '0;
      end else begin
         state     <= state_nxt;
         sr        <= sr_nxt;
         word_out  <= word_nxt;
         bit_count <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      sr_nxt    = sr;
      word_nxt  = word_out;
      cnt_nxt   = bit_count;
      if (flush) begin
         state_nxt = COLLECT;
         sr_nxt    = '0;
         cnt_nxt   = '0;
      end else begin
         case (state)
            COLLECT: begin
               if (accept) begin
                  if (bit_count == LAST) begin
                     word_nxt  = {sr[WIDTH-2:0], ser_in};
                     sr_nxt    = '0;
                     cnt_nxt   = '0;
                     state_nxt = HOLD;
                  end else begin
                     sr_nxt  = {sr[WIDTH-2:0], ser_in};
                     cnt_nxt = bit_count + 5'd1;
                  end
               end
            end
            HOLD: begin
               if (word_ready) begin
                  state_nxt = COLLECT;
                  // Back-to-back: the bit arriving with the handoff starts the next frame.
                  if (accept) begin
                     sr_nxt  = {{(WIDTH-1){1'b0}}, ser_in};
                     cnt_nxt = 5'd1;
                  end
               end
            end
            default: state_nxt = COLLECT;
         endcase
      end
   end

endmodule
